// File: rtl/uart_tx_gen.sv
// uart_tx_gen: 16550-style UART transmit framer.
// Serialises one character per frame: start bit, 5-8 data bits LSB first,
// optional parity, 1/1.5/2 stop bits, then GUARD_BITS idle bit times.
// All timing advances on i_baud_pulse; each bit lasts OVERSAMPLE ticks.
// Optional feature macro: UART_TX_PARITY_EN (parity state and logic).
// Without it, i_pen/i_eps/i_sticky_parity are ignored and DATA goes to STOP.
module uart_tx_gen #(
    parameter int OVERSAMPLE = 16,
    parameter int GUARD_BITS = 0
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_baud_pulse,
    input  logic       i_thre,
    input  logic [7:0] i_din,
    input  logic [1:0] i_wls,
    input  logic       i_pen,
    input  logic       i_eps,
    input  logic       i_sticky_parity,
    input  logic       i_stb,
    input  logic       i_set_break,
    output logic       o_pop,
    output logic       o_sreg_empty,
    output logic       o_tx,
    output logic       o_busy,
    output logic       o_tx_done
);

    localparam int STOP1_T  = OVERSAMPLE;
    localparam int STOP15_T = (3 * OVERSAMPLE) / 2;
    localparam int STOP2_T  = 2 * OVERSAMPLE;
    localparam int GUARD_T  = GUARD_BITS * OVERSAMPLE;
    // Counter must hold the longest single state: 2-bit stop or the guard span
    localparam int MAX_T    = (GUARD_T > STOP2_T) ? GUARD_T : STOP2_T;
    localparam int CNT_W    = $clog2(MAX_T + 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, GUARD} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, GUARD} state_t;
`endif

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bit;
    logic [7:0]       r_sreg;
    logic [1:0]       r_wls;
    logic             r_stb;
    logic             r_line;
    logic             r_tx;
    logic             r_pop;
    logic             r_sreg_empty;
    logic             r_busy;
    logic             r_tx_done;

    logic [CNT_W-1:0] w_len;
    logic             w_last;
    logic [2:0]       w_last_bit;

`ifdef UART_TX_PARITY_EN
    logic       r_pen;
    logic       r_par;
    logic [7:0] w_mask;
    logic       w_par;

    // Parity over the selected word length, taken from din at load time
    always_comb begin
        w_mask = 8'hFF >> (2'd3 - i_wls);
        if (i_sticky_parity)
            w_par = ~i_eps;
        else
            w_par = (^(i_din & w_mask)) ^ ~i_eps;
    end
`else
    logic w_unused_parity;
    assign w_unused_parity = ^{i_pen, i_eps, i_sticky_parity};
`endif

    // Tick length of the current state; stop length uses the latched LCR
    always_comb begin
        w_len = CNT_W'(OVERSAMPLE);
        case (r_state)
            STOP:    w_len = !r_stb ? CNT_W'(STOP1_T) :
                             (r_wls == 2'd0) ? CNT_W'(STOP15_T) : CNT_W'(STOP2_T);
            GUARD:   w_len = CNT_W'(GUARD_T);
            default: w_len = CNT_W'(OVERSAMPLE);
        endcase
    end

    assign w_last     = (r_cnt == w_len - 1'b1);
    assign w_last_bit = {1'b0, r_wls} + 3'd4;

    // Frame FSM; tx is re-registered every clk so a break shows on the next edge
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_bit        <= '0;
            r_sreg       <= '0;
            r_wls        <= '0;
            r_stb        <= 1'b0;
`ifdef UART_TX_PARITY_EN
            r_pen        <= 1'b0;
            r_par        <= 1'b0;
`endif
            r_line       <= 1'b1;
            r_tx         <= 1'b1;
            r_pop        <= 1'b0;
            r_sreg_empty <= 1'b1;
            r_busy       <= 1'b0;
            r_tx_done    <= 1'b0;
        end else begin
            r_pop     <= 1'b0;
            r_tx_done <= 1'b0;
            r_tx      <= r_line & ~i_set_break;
            if (i_baud_pulse) begin
                case (r_state)
                    IDLE: begin
                        if (!i_thre) begin
                            r_state      <= START;
                            r_cnt        <= '0;
                            r_sreg       <= i_din;
                            r_wls        <= i_wls;
                            r_stb        <= i_stb;
`ifdef UART_TX_PARITY_EN
                            r_pen        <= i_pen;
                            r_par        <= w_par;
`endif
                            r_pop        <= 1'b1;
                            r_sreg_empty <= 1'b0;
                            r_busy       <= 1'b1;
                            r_line       <= 1'b0;
                            r_tx         <= 1'b0;
                        end
                    end
                    START: begin
                        if (w_last) begin
                            r_state <= DATA;
                            r_cnt   <= '0;
                            r_bit   <= '0;
                            r_line  <= r_sreg[0];
                            r_tx    <= r_sreg[0] & ~i_set_break;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    DATA: begin
                        if (!w_last) begin
                            r_cnt <= r_cnt + 1'b1;
                        end else if (r_bit != w_last_bit) begin
                            r_cnt  <= '0;
                            r_bit  <= r_bit + 1'b1;
                            r_sreg <= {1'b0, r_sreg[7:1]};
                            r_line <= r_sreg[1];
                            r_tx   <= r_sreg[1] & ~i_set_break;
`ifdef UART_TX_PARITY_EN
                        end else if (r_pen) begin
                            r_state <= PARITY;
                            r_cnt   <= '0;
                            r_line  <= r_par;
                            r_tx    <= r_par & ~i_set_break;
`endif
                        end else begin
                            r_state      <= STOP;
                            r_cnt        <= '0;
                            r_sreg_empty <= 1'b1;
                            r_line       <= 1'b1;
                            r_tx         <= ~i_set_break;
                        end
                    end
`ifdef UART_TX_PARITY_EN
                    PARITY: begin
                        if (w_last) begin
                            r_state      <= STOP;
                            r_cnt        <= '0;
                            r_sreg_empty <= 1'b1;
                            r_line       <= 1'b1;
                            r_tx         <= ~i_set_break;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
`endif
                    STOP: begin
                        if (!w_last) begin
                            r_cnt <= r_cnt + 1'b1;
                        end else if (GUARD_T == 0) begin
                            r_state   <= IDLE;
                            r_cnt     <= '0;
                            r_busy    <= 1'b0;
                            r_tx_done <= 1'b1;
                        end else begin
                            r_state <= GUARD;
                            r_cnt   <= '0;
                        end
                    end
                    GUARD: begin
                        if (w_last) begin
                            r_state   <= IDLE;
                            r_cnt     <= '0;
                            r_busy    <= 1'b0;
                            r_tx_done <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                    end
                endcase
            end
        end
    end

    assign o_pop        = r_pop;
    assign o_sreg_empty = r_sreg_empty;
    assign o_tx         = r_tx;
    assign o_busy       = r_busy;
    assign o_tx_done    = r_tx_done;

endmodule

// File: tb/tb_uart_tx_gen.sv
// tb_uart_tx_gen: table of directed frames plus random frames, each checked
// tick by tick against a bit-list model of the serial line.
module tb_uart_tx_gen;

    localparam int OS = 16;
`ifdef UART_TX_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    typedef struct {
        bit [7:0] din;
        bit [1:0] wls;
        bit       pen, eps, sp, stb;
        int       per;     // clks per baud tick
        int       brk;     // tick at which set_break rises, -1 none
        int       len_np;  // frame ticks without parity bit (hand derived)
        int       par;     // expected parity bit, -1 when pen=0
    } vec_t;

    logic clk, rst_n, baud, thre0, thre1, pen, eps, sp, stb, brk, sel;
    logic [7:0] din;
    logic [1:0] wls;
    logic pop0, se0, tx0, busy0, done0;
    logic pop1, se1, tx1, busy1, done1;

    wire s_pop  = sel ? pop1  : pop0;
    wire s_se   = sel ? se1   : se0;
    wire s_tx   = sel ? tx1   : tx0;
    wire s_busy = sel ? busy1 : busy0;
    wire s_done = sel ? done1 : done0;

    uart_tx_gen #(.OVERSAMPLE(OS), .GUARD_BITS(0)) u_dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_baud_pulse(baud), .i_thre(thre0),
        .i_din(din), .i_wls(wls), .i_pen(pen), .i_eps(eps),
        .i_sticky_parity(sp), .i_stb(stb), .i_set_break(brk),
        .o_pop(pop0), .o_sreg_empty(se0), .o_tx(tx0), .o_busy(busy0),
        .o_tx_done(done0));

    uart_tx_gen #(.OVERSAMPLE(OS), .GUARD_BITS(2)) u_dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_baud_pulse(baud), .i_thre(thre1),
        .i_din(din), .i_wls(wls), .i_pen(pen), .i_eps(eps),
        .i_sticky_parity(sp), .i_stb(stb), .i_set_break(brk),
        .o_pop(pop1), .o_sreg_empty(se1), .o_tx(tx1), .o_busy(busy1),
        .o_tx_done(done1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int per = 1;
    int ph = 0;
    bit last_tick;
    int exp_q[$];

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // One clock; remembers whether that edge carried a baud tick
    task automatic step();
        last_tick = baud;
        @(posedge clk);
        #1;
        ph   = (ph + 1 >= per) ? 0 : ph + 1;
        baud = (ph == 0);
    endtask

    function automatic vec_t mk(input bit [7:0] d, input bit [1:0] w, input bit p,
                                input bit e, input bit s, input bit b, input int pr,
                                input int bk, input int ln, input int pb);
        vec_t v;
        v.din = d; v.wls = w; v.pen = p; v.eps = e; v.sp = s; v.stb = b;
        v.per = pr; v.brk = bk; v.len_np = ln; v.par = pb;
        return v;
    endfunction

    // Line level per tick for one frame, from the framing rules
    task automatic build_exp(input vec_t v, input int gbits, output int s_tick);
        int nb, ones, stop_t;
        bit pb;
        nb = int'(v.wls) + 5;
        ones = 0;
        exp_q.delete();
        for (int i = 0; i < OS; i++) exp_q.push_back(0);
        for (int b = 0; b < nb; b++) begin
            ones += int'(v.din[b]);
            for (int i = 0; i < OS; i++) exp_q.push_back(int'(v.din[b]));
        end
        if (PAR && v.pen) begin
            if (v.sp)       pb = !v.eps;
            else if (v.eps) pb = (ones % 2) == 1;
            else            pb = (ones % 2) == 0;
            for (int i = 0; i < OS; i++) exp_q.push_back(int'(pb));
        end
        s_tick = exp_q.size();
        stop_t = !v.stb ? OS : (v.wls == 2'd0 ? (3 * OS) / 2 : 2 * OS);
        for (int i = 0; i < stop_t + gbits * OS; i++) exp_q.push_back(1);
    endtask

    task automatic run_frame(input vec_t v, input bit s, input int gbits, input bit keep,
                             input int exp_len, input string nm, output int waited);
        int s_tick, tk, nbad, nbad_se, npop, done_tk, clks, par_seen, par_tick, t_len;
        bit brk_act;
        logic exp_tx;
        sel = s; per = v.per;
        din = v.din; wls = v.wls; pen = v.pen; eps = v.eps; sp = v.sp; stb = v.stb;
        brk = 1'b0;
        if (s) thre1 = 1'b0; else thre0 = 1'b0;
        build_exp(v, gbits, s_tick);
        t_len = exp_q.size();
        if (exp_len < 0) exp_len = t_len;
        par_tick = OS * (int'(v.wls) + 6) + OS / 2;
        waited = 0;
        while (s_pop !== 1'b1 && waited < 4) begin
            step();
            if (last_tick) waited++;
        end
        chk({nm, " start pop"}, int'(s_pop === 1'b1), 1);
        if (s_pop !== 1'b1) begin
            thre0 = 1'b1; thre1 = 1'b1;
            return;
        end
        if (!keep) begin thre0 = 1'b1; thre1 = 1'b1; end
        // LCR and din are latched; scrambling them now must not matter
        din = 8'($urandom); wls = 2'($urandom); pen = 1'($urandom);
        eps = 1'($urandom); sp = 1'($urandom); stb = 1'($urandom);
        tk = 0; nbad = 0; nbad_se = 0; npop = 1; done_tk = -1; clks = 0;
        par_seen = -1; brk_act = 1'b0;
        while (done_tk < 0 && tk <= t_len + 4) begin
            exp_tx = (tk < t_len) ? (exp_q[tk] != 0) : 1'b1;
            if (brk_act) exp_tx = 1'b0;
            if (s_tx !== exp_tx) nbad++;
            if (tk < t_len && (s_busy !== 1'b1 || s_se !== (tk >= s_tick)) ) nbad_se++;
            if (tk == par_tick && !brk_act) par_seen = int'(s_tx);
            if (s_done === 1'b1) begin
                done_tk = tk;
            end else begin
                if (v.brk >= 0 && tk == v.brk) brk = 1'b1;
                step();
                clks++;
                if (brk) brk_act = 1'b1;
                if (last_tick) tk++;
                if (s_pop === 1'b1) npop++;
            end
        end
        brk = 1'b0;
        chk({nm, " tx wave bad samples"}, nbad, 0);
        chk({nm, " busy/sreg_empty bad samples"}, nbad_se, 0);
        chk({nm, " frame ticks"}, done_tk, exp_len);
        chk({nm, " clks start->done"}, clks, exp_len * v.per);
        chk({nm, " pops"}, npop, 1);
        chk({nm, " busy at done"}, int'(s_busy), 0);
        if (PAR && v.par >= 0) chk({nm, " parity bit"}, par_seen, v.par);
        if (!keep) begin
            step();
            chk({nm, " tx_done width"}, int'(s_done), 0);
        end
    endtask

    vec_t tbl[10];
    vec_t v;
    int   waited, tk, npop, len;
    bit   prev_keep, keep;

    initial begin
        rst_n = 1'b0; baud = 1'b1; thre0 = 1'b0; thre1 = 1'b0; sel = 1'b0;
        din = 8'h00; wls = 2'd0; pen = 1'b0; eps = 1'b0; sp = 1'b0; stb = 1'b0; brk = 1'b0;

        // Reset state; thre low and baud high must not pop during reset
        npop = 0;
        repeat (4) begin step(); npop += int'(pop0) + int'(pop1); end
        chk("reset tx", int'(tx0), 1);
        chk("reset busy", int'(busy0), 0);
        chk("reset sreg_empty", int'(se0), 1);
        chk("reset tx_done", int'(done0 | done1), 0);
        chk("reset pops", npop, 0);
        thre0 = 1'b1; thre1 = 1'b1;
        rst_n = 1'b1;
        step();

        //            din    wls  pen eps sp stb per brk  len_np par
        tbl[0] = mk(8'h13, 2'd3, 0, 0, 0, 0, 1, -1, 160, -1);
        tbl[1] = mk(8'h13, 2'd3, 1, 1, 0, 1, 1, -1, 176,  1);
        tbl[2] = mk(8'h13, 2'd3, 1, 0, 0, 1, 1, -1, 176,  0);
        tbl[3] = mk(8'h1F, 2'd0, 0, 0, 0, 1, 1, -1, 120, -1);
        tbl[4] = mk(8'h1F, 2'd0, 1, 1, 1, 1, 1, -1, 120,  0);
        tbl[5] = mk(8'hA5, 2'd1, 1, 0, 0, 0, 1, -1, 128,  0);
        tbl[6] = mk(8'h5A, 2'd2, 1, 0, 1, 1, 1, -1, 160,  1);
        tbl[7] = mk(8'h13, 2'd3, 0, 0, 0, 0, 1, 40, 160, -1);
        tbl[8] = mk(8'hC3, 2'd3, 0, 0, 0, 1, 3, -1, 176, -1);
        tbl[9] = mk(8'h00, 2'd1, 1, 1, 0, 0, 2, 70, 128,  0);
        for (int i = 0; i < 10; i++) begin
            len = tbl[i].len_np + ((PAR && tbl[i].par >= 0) ? OS : 0);
            run_frame(tbl[i], 1'b0, 0, 1'b0, len, $sformatf("vec%0d", i), waited);
        end

        // Three back-to-back characters with two guard bits, baud every 6th clk
        for (int i = 0; i < 3; i++) begin
            v = mk(8'h41 + 8'(i), 2'd3, 0, 0, 0, 0, 6, -1, 192, -1);
            run_frame(v, 1'b1, 2, (i < 2), 192, $sformatf("guard%0d", i), waited);
            if (i > 0) chk($sformatf("guard%0d ticks idle before start", i), waited, 1);
        end

        // Random frames, sometimes back-to-back
        prev_keep = 1'b0;
        for (int i = 0; i < 24; i++) begin
            v = mk(8'($urandom), 2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                   1'($urandom), $urandom_range(1, 3), -1, 0, -1);
            if ($urandom_range(0, 3) == 0) v.brk = $urandom_range(0, 100);
            keep = (i < 23) ? 1'($urandom) : 1'b0;
            run_frame(v, 1'b0, 0, keep, -1, $sformatf("rnd%0d", i), waited);
            if (prev_keep) chk($sformatf("rnd%0d ticks idle before start", i), waited, 1);
            prev_keep = keep;
        end

        // Reset during the third data bit, then a clean frame
        sel = 1'b0; per = 1; din = 8'h13; wls = 2'd3; pen = 1'b0; stb = 1'b0; thre0 = 1'b0;
        waited = 0;
        while (pop0 !== 1'b1 && waited < 8) begin step(); waited++; end
        thre0 = 1'b1;
        tk = 0;
        while (tk < 50) begin step(); if (last_tick) tk++; end
        chk("pre-reset busy", int'(busy0), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("midframe reset tx", int'(tx0), 1);
        chk("midframe reset busy", int'(busy0), 0);
        chk("midframe reset sreg_empty", int'(se0), 1);
        chk("midframe reset pop/done", int'(pop0 | done0), 0);
        thre0 = 1'b0; npop = 0;
        repeat (4) begin step(); npop += int'(pop0); end
        chk("midframe reset pops", npop, 0);
        thre0 = 1'b1;
        rst_n = 1'b1;
        step();
        run_frame(tbl[0], 1'b0, 0, 1'b0, 160, "after reset", waited);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
